// File: rtl/cohub_lock_arb_pkg.sv
// Shared constants, FSM state type and index helper for the coherency-hub lock arbiter.
package cohub_pkg;

  localparam int PN_DEF  = 3;
  localparam int TMO_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cohub_lock_arb_if.sv
// Lock request/grant bundle between hub ports (master) and the lock arbiter (slave).
interface cohub_lock_arb_if #(parameter int PN = cohub_pkg::PN_DEF);

  localparam int OW = (PN > 1) ? $clog2(PN) : 1;

  logic [PN-1:0] lock_req;
  logic [PN-1:0] lock_gnt;
  logic [PN-1:0] lock_abort;
  logic [OW-1:0] owner;
  logic          owner_vld;
  logic [7:0]    tmo_cnt;

  modport master (
    output lock_req,
    input  lock_gnt, lock_abort, owner, owner_vld, tmo_cnt
  );

  modport slave (
    input  lock_req,
    output lock_gnt, lock_abort, owner, owner_vld, tmo_cnt
  );

endinterface

// File: rtl/cohub_lock_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or above ptr, else wraps to the lowest.
module rr_pick #(
  parameter int PN = 3,
  parameter int OW = 2
) (
  input  logic [PN-1:0] eligible,
  input  logic [OW-1:0] ptr,
  output logic [PN-1:0] pick,
  output logic [OW-1:0] idx
);

  logic found;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    // Upper segment [ptr, PN-1] has priority, lower segment only when it is empty.
    for (int i = 0; i < PN; i++) begin
      if (!found && eligible[i] && (i >= int'(ptr))) begin
        found   = 1'b1;
        pick[i] = 1'b1;
        idx     = OW'(i);
      end
    end
    for (int i = 0; i < PN; i++) begin
      if (!found && eligible[i]) begin
        found   = 1'b1;
        pick[i] = 1'b1;
        idx     = OW'(i);
      end
    end
  end

endmodule

// File: rtl/cohub_lock_arb.sv
// Round-robin lock arbiter with hold timeout, per-port block-until-release and timeout counter.
//   state | meaning
//   IDLE  | no owner; grant the next eligible port on the following edge
//   HOLD  | one port owns the lock; other requests are ignored
//   GAP   | single no-grant cycle after release or timeout; arbitrates like IDLE
module cohub_lock_arb
  import cohub_pkg::*;
#(
  parameter int PN  = PN_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  cohub_lock_arb_if.slave  bus
);

  localparam int OW = (PN > 1) ? $clog2(PN) : 1;
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'((TMO > 0) ? TMO - 1 : 0);

  state_e        state;
  logic [PN-1:0] blk;
  logic [PN-1:0] elig;
  logic [PN-1:0] pick;
  logic [OW-1:0] pick_idx;
  logic [OW-1:0] ptr;
  logic [OW-1:0] owner_r;
  logic [OW-1:0] next_ptr;
  logic [TW-1:0] timer;
  logic [PN-1:0] gnt_r;
  logic [PN-1:0] abort_r;
  logic          vld_r;
  logic [7:0]    tmo_r;
  logic          own_req;
  logic          tmo_hit;

  assign elig     = bus.lock_req & ~blk;
  assign own_req  = bus.lock_req[owner_r];
  assign tmo_hit  = (TMO != 0) && (timer == TMR_LAST);
  assign next_ptr = OW'(wrap_inc(int'(owner_r), PN));

  rr_pick #(.PN(PN), .OW(OW)) u_pick (
    .eligible (elig),
    .ptr      (ptr),
    .pick     (pick),
    .idx      (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      blk     <= '0;
      ptr     <= '0;
      owner_r <= '0;
      timer   <= '0;
      gnt_r   <= '0;
      abort_r <= '0;
      vld_r   <= 1'b0;
      tmo_r   <= '0;
    end else begin
      abort_r <= '0;
      blk     <= blk & bus.lock_req;
      case (state)
        ST_HOLD: begin
          if (!own_req) begin
            state <= ST_GAP;
            gnt_r <= '0;
            vld_r <= 1'b0;
            ptr   <= next_ptr;
          end else if (tmo_hit) begin
            // Revoked owner stays blocked until it drops its request.
            state   <= ST_GAP;
            gnt_r   <= '0;
            vld_r   <= 1'b0;
            ptr     <= next_ptr;
            abort_r <= gnt_r;
            blk     <= (blk & bus.lock_req) | gnt_r;
            if (tmo_r != 8'hFF) tmo_r <= tmo_r + 8'd1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          if (|elig) begin
            state   <= ST_HOLD;
            gnt_r   <= pick;
            vld_r   <= 1'b1;
            owner_r <= pick_idx;
            timer   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.lock_gnt   = gnt_r;
  assign bus.lock_abort = abort_r;
  assign bus.owner      = owner_r;
  assign bus.owner_vld  = vld_r;
  assign bus.tmo_cnt    = tmo_r;

endmodule

// File: tb/tb_cohub_lock_arb.sv
// Randomised and directed bench for cohub_lock_arb against a cycle-level behavioural model.
module tb_cohub_lock_arb;
  import cohub_pkg::*;

  localparam int PN  = 3;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cohub_lock_arb_if #(.PN(PN)) bus();

  cohub_lock_arb #(.PN(PN), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: owner index (-1 = none), cycles held, next search start, blocked set.
  int            m_owner;
  int            m_hold;
  int            m_ptr;
  logic [PN-1:0] m_blk;
  int            m_tmo;
  int            m_timeouts;
  logic [PN-1:0] m_abort;

  task automatic m_reset();
    m_owner = -1;
    m_hold  = 0;
    m_ptr   = 0;
    m_blk   = '0;
    m_tmo   = 0;
    m_abort = '0;
  endtask

  task automatic m_step(input logic [PN-1:0] r);
    logic [PN-1:0] elig;
    elig    = r & ~m_blk;
    m_abort = '0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_ptr   = (m_owner + 1) % PN;
        m_owner = -1;
      end else if (TMO > 0 && m_hold == TMO - 1) begin
        m_abort[m_owner] = 1'b1;
        m_blk[m_owner]   = 1'b1;
        m_ptr            = (m_owner + 1) % PN;
        if (m_tmo < 255) m_tmo++;
        m_timeouts++;
        m_owner = -1;
      end else begin
        m_hold++;
      end
    end else if (elig != '0) begin
      for (int k = 0; k < PN; k++) begin
        int p;
        p = (m_ptr + k) % PN;
        if (m_owner < 0 && elig[p]) begin
          m_owner = p;
          m_hold  = 0;
        end
      end
    end
    for (int i = 0; i < PN; i++)
      if (!r[i]) m_blk[i] = 1'b0;
  endtask

  task automatic compare();
    logic [PN-1:0] eg;
    eg = (m_owner >= 0) ? PN'(1 << m_owner) : '0;
    check("lock_gnt",   32'(bus.lock_gnt),   32'(eg));
    check("lock_abort", 32'(bus.lock_abort), 32'(m_abort));
    check("owner_vld",  32'(bus.owner_vld),  32'(m_owner >= 0));
    check("tmo_cnt",    32'(bus.tmo_cnt),    32'(m_tmo));
    check("gnt_onehot", 32'($onehot0(bus.lock_gnt)), 32'd1);
    if (m_owner >= 0) check("owner", 32'(bus.owner), 32'(m_owner));
  endtask

  task automatic step(input logic [PN-1:0] r);
    bus.lock_req = r;
    @(posedge clk);
    m_step(r);
    @(negedge clk);
    compare();
  endtask

  initial begin
    logic [PN-1:0] r;
    logic [PN-1:0] prev_gnt;
    int            nseq;
    int            hi_cnt;
    int            ab_cnt;

    m_timeouts   = 0;
    rst          = 1'b1;
    bus.lock_req = '0;
    m_reset();
    repeat (2) @(negedge clk);
    compare();
    rst = 1'b0;
    step('0);
    step('0);

    // Rotation with all ports requesting; owner drops for one cycle to release.
    nseq     = 0;
    prev_gnt = '0;
    for (int c = 0; c < 30; c++) begin
      r = 3'b111;
      if (m_owner >= 0 && m_hold == 2) r[m_owner] = 1'b0;
      step(r);
      if (bus.lock_gnt != '0 && prev_gnt == '0) begin
        check("rotation", 32'(bus.lock_gnt), 32'(1 << (nseq % 3)));
        nseq++;
      end
      prev_gnt = bus.lock_gnt;
    end
    step('0);
    step('0);

    // Single port holds then releases.
    repeat (7) step(3'b010);
    repeat (3) step(3'b000);

    // Port 0 holds past the timeout.
    hi_cnt = 0;
    ab_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step(3'b001);
      if (bus.lock_gnt[0]) hi_cnt++;
      if (bus.lock_abort == 3'b001) ab_cnt++;
    end
    check("tmo_hold_cycles", 32'(hi_cnt), 32'd8);
    check("tmo_abort_pulses", 32'(ab_cnt), 32'd1);
    check("tmo_cnt_one", 32'(bus.tmo_cnt), 32'd1);
    check("tmo_blocked", 32'(bus.lock_gnt), 32'd0);
    repeat (2) step(3'b000);

    // Release coinciding with the timeout cycle is a normal release.
    for (int c = 0; c < 20; c++) begin
      if (m_owner == 0 && m_hold == TMO - 1) break;
      step(3'b001);
    end
    step(3'b000);
    check("release_at_tmo_abort", 32'(bus.lock_abort), 32'd0);
    check("release_at_tmo_cnt", 32'(bus.tmo_cnt), 32'd1);
    step(3'b000);

    // Reset in the middle of a hold by port 2.
    repeat (3) step(3'b100);
    check("pre_rst_gnt", 32'(bus.lock_gnt), 32'b100);
    #2 rst = 1'b1;
    #1;
    check("rst_async_gnt", 32'(bus.lock_gnt), 32'd0);
    check("rst_async_abort", 32'(bus.lock_abort), 32'd0);
    m_reset();
    @(negedge clk);
    compare();
    rst = 1'b0;
    step(3'b111);
    check("post_rst_lowest", 32'(bus.lock_gnt), 32'b001);
    step(3'b000);
    step(3'b000);

    // Random request traffic.
    r = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < PN; i++)
        if ($urandom_range(4) == 0) r[i] = ~r[i];
      step(r);
    end

    // Force timeouts until the counter saturates.
    ab_cnt = 0;
    for (int c = 0; c < 6000 && m_timeouts < 300; c++) begin
      step(3'b111 & ~m_blk);
      if (bus.lock_abort != '0) ab_cnt++;
    end
    check("tmo_saturated", 32'(bus.tmo_cnt), 32'd255);
    check("tmo_many_aborts", 32'(ab_cnt >= 250), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
